// File: rtl/audio_pkg.sv
// Shared types and constants for the audio I2S transmit path.
//
// Contents:
//   audio_sample_t  - signed 16-bit two's complement sample
//   state_e         - serializer state (IDLE, RUN)
//   SILENCE_OFFSET  - mid-scale code of the mixer's offset-binary output
//   offset_to_twos  - offset-binary to two's complement conversion
//
// Optional feature macro used by this codebase: AUDIO_DCBLOCK_EN.
package audio_pkg;

   typedef logic signed [15:0] audio_sample_t;

   typedef enum logic [0:0] {
      IDLE,
      RUN
   } state_e;

   localparam logic [15:0] SILENCE_OFFSET = 16'h8000;

   // Flipping the MSB of an offset-binary code gives its two's complement value.
   function automatic audio_sample_t offset_to_twos(input logic [15:0] s);
      return audio_sample_t'(s ^ SILENCE_OFFSET);
   endfunction

endpackage

// File: rtl/audio_dc_block.sv
// First-order DC blocker: y = x - x_prev + y_prev - (y_prev >>> 8).
// Arithmetic is 18-bit signed; the result saturates to 16 bits and the saturated
// value is what feeds back as y_prev. One clk of latency from x_valid to y_valid.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (filter state cleared to 0)
//   x        in   converted two's complement sample
//   x_valid  in   strobe qualifying x
//   y        out  filtered sample
//   y_valid  out  strobe qualifying y, one clk after x_valid
//
// The module only exists when AUDIO_DCBLOCK_EN is defined.
`ifdef AUDIO_DCBLOCK_EN
module audio_dc_block
   import audio_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  audio_sample_t x,
   input  logic          x_valid,
   output audio_sample_t y,
   output logic          y_valid
);

   audio_sample_t      x_prev_q;
   audio_sample_t      y_q;
   logic               valid_q;
   logic signed [17:0] acc;
   audio_sample_t      sat;

   // |x - x_prev| <= 65535 and |y - y>>>8| < 32768, so the sum fits in 18 bits.
   always_comb begin
      acc = 18'(x) - 18'(x_prev_q) + 18'(y_q) - 18'(y_q >>> 8);
      if (acc > 18'sd32767) begin
         sat = 16'sh7FFF;
      end else if (acc < -18'sd32768) begin
         sat = 16'sh8000;
      end else begin
         sat = acc[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_prev_q <= '0;
         y_q      <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= x_valid;
         if (x_valid) begin
            x_prev_q <= x;
            y_q      <= sat;
         end
      end
   end

   assign y       = y_q;
   assign y_valid = valid_q;

endmodule
`endif

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the mixed mono sound sample.
// Converts the mixer's offset-binary sample to two's complement, holds it in a
// one-deep buffer and sends it MSB-first in both the left and right slots of an
// I2S frame. BCLK and LRCK are derived locally from clk.
//
// Parameters:
//   BCLK_HALF  clk cycles per BCLK half-period (>= 2)
//   SLOT_BITS  BCLK cycles per channel slot (16..32), zero padded after the LSB
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   enable        in   run the serializer; dropping it stops at the next frame boundary
//   sample_in     in   16-bit unsigned offset-binary sample (16'h8000 = silence)
//   sample_valid  in   one-clk strobe qualifying sample_in
//   clear_status  in   clears the sticky flags
//   i2s_bclk      out  bit clock
//   i2s_lrck      out  word select, 0 = left
//   i2s_data      out  serial data, updated on BCLK falling edges
//   underrun      out  sticky: frame started without a new sample
//   overrun       out  sticky: buffered sample overwritten before use
//
// Optional feature: define AUDIO_DCBLOCK_EN to insert audio_dc_block after the
// conversion (adds one clk to the hold fill).
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int unsigned BCLK_HALF = 8,
   parameter int unsigned SLOT_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] sample_in,
   input  logic        sample_valid,
   input  logic        clear_status,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_data,
   output logic        underrun,
   output logic        overrun
);

   localparam int unsigned DIV_W = $clog2(BCLK_HALF);
   localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);

   // ---------------------------------------------------------------------------
   // Input conversion and optional DC blocking
   // ---------------------------------------------------------------------------
   audio_sample_t conv;
   audio_sample_t fill_data;
   logic          fill_valid;

   assign conv = offset_to_twos(sample_in);

`ifdef AUDIO_DCBLOCK_EN
   audio_dc_block u_dc_block (
      .clk     (clk),
      .rst     (rst),
      .x       (conv),
      .x_valid (sample_valid),
      .y       (fill_data),
      .y_valid (fill_valid)
   );
`else
   assign fill_data  = conv;
   assign fill_valid = sample_valid;
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bclk_q, bclk_d;
   logic              lrck_q, lrck_d;
   logic              data_q, data_d;
   audio_sample_t     hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   audio_sample_t     word_q, word_d;
   logic              underrun_q, underrun_d;
   logic              overrun_q, overrun_d;

   logic              load;
   logic [CNT_W-1:0]  cnt_inc;

   // Bit driven while the counter holds c. The one-BCLK I2S delay means counter
   // value c carries slot bit c-1; c == 0 carries the last bit of the right slot.
   function automatic logic slot_bit(input audio_sample_t w, input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] b;
      logic [3:0]       idx;
      if (c == '0) begin
         b = CNT_SLOT - 1'b1;
      end else if (c > CNT_SLOT) begin
         b = c - CNT_SLOT - 1'b1;
      end else begin
         b = c - 1'b1;
      end
      idx = ~b[3:0];
      if (b[CNT_W-1:4] == '0) begin
         slot_bit = w[idx];
      end else begin
         slot_bit = 1'b0;
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      bclk_d      = bclk_q;
      lrck_d      = lrck_q;
      data_d      = data_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      word_d      = word_q;
      underrun_d  = underrun_q;
      overrun_d   = overrun_q;
      load        = 1'b0;
      cnt_inc     = cnt_q + 1'b1;

      if (clear_status) begin
         underrun_d = 1'b0;
         overrun_d  = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            div_d  = '0;
            cnt_d  = '0;
            bclk_d = 1'b0;
            lrck_d = 1'b0;
            data_d = 1'b0;
            // Entering RUN is itself a frame boundary: the buffered word is loaded.
            if (enable && hold_full_q) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end

         RUN: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               bclk_d = ~bclk_q;
               // bclk currently high: this wrap is a falling edge, the update point.
               if (bclk_q) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d  = '0;
                     lrck_d = 1'b0;
                     if (!enable) begin
                        state_d = IDLE;
                        data_d  = 1'b0;
                     end else begin
                        // Final bit of the outgoing frame still comes from the old word.
                        data_d = slot_bit(word_q, '0);
                        load   = 1'b1;
                        if (!hold_full_q) begin
                           underrun_d = 1'b1;
                        end
                     end
                  end else begin
                     cnt_d  = cnt_inc;
                     lrck_d = (cnt_inc >= CNT_SLOT);
                     data_d = slot_bit(word_q, cnt_inc);
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      // Underrun keeps the previous word; the load always empties the buffer.
      if (load) begin
         if (hold_full_q) begin
            word_d = hold_q;
         end
         hold_full_d = 1'b0;
      end

      // A fill on the same clk as a load refills the just-emptied buffer.
      if (fill_valid) begin
         hold_d      = fill_data;
         hold_full_d = 1'b1;
         if (hold_full_q && !load) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         div_q       <= '0;
         cnt_q       <= '0;
         bclk_q      <= 1'b0;
         lrck_q      <= 1'b0;
         data_q      <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         word_q      <= '0;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         bclk_q      <= bclk_d;
         lrck_q      <= lrck_d;
         data_q      <= data_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         word_q      <= word_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
      end
   end

   assign i2s_bclk = bclk_q;
   assign i2s_lrck = lrck_q;
   assign i2s_data = data_q;
   assign underrun = underrun_q;
   assign overrun  = overrun_q;

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Consumer of the 16-bit mixed sound sample from the analog sound mixer.
- Converts the mixer's unsigned, offset-binary sample to two's complement.
- Double-buffers the sample and serialises it as a mono-duplicated stereo I2S stream for the board audio codec/HDMI audio path.
- Generates BCLK/LRCK locally from clk and reports underrun/overrun sticky status.

Parameters:
- BCLK_HALF, 8, clk cycles per BCLK half-period (≥2); BCLK = clk/(2*BCLK_HALF).
- SLOT_BITS, 16, BCLK cycles per channel slot (16..32); sample MSB-first, padded with zeros after LSB.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run serializer; low → return to IDLE at next frame boundary
- sample_in  in  16  unsigned mixer sample (mid-scale = 16'h8000 silence)
- sample_valid  in  1  one-clk strobe qualifying sample_in (tied to 48 kHz enable)
- clear_status  in  1  clears sticky flags
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select, 0 = left
- i2s_data  out  1  serial data
- underrun  out  1  sticky: frame started with no new sample
- overrun  out  1  sticky: second sample_valid before frame consumed first

Behaviour:
- Reset (async, rst=1): all outputs 0, hold register 0, hold_full 0, shift register 0, divider 0, bit counter 0, state IDLE.
- Input conversion: hold <= {~sample_in[15], sample_in[14:0]} on sample_valid; hold_full <= 1.
- States:
  - IDLE: bclk/lrck/data held 0. Go to RUN when enable=1 and hold_full=1.
  - RUN: divider counts 0..BCLK_HALF-1.
    - Wrap toggles bclk. Falling edge of bclk is the update point.
    - Bit counter 0..2*SLOT_BITS-1 advances on each falling edge.
    - lrck = counter ≥ SLOT_BITS.
  - Frame boundary: counter wraps to 0 (lrck falls) on a falling edge.
    - Shift register loads the hold value; hold_full cleared.
    - If hold_full was 0, the previous word is reused and underrun set.
    - If enable=0 at the boundary, go to IDLE instead.
- I2S timing:
  - Data MSB appears on the falling edge one BCLK after the lrck transition (standard I2S delay).
  - Same 16-bit word in both slots; bits beyond the LSB are 0.
  - Data is stable across the bclk rising edge.
- Latency: a sample strobed before a frame boundary drives its MSB exactly 1 BCLK period after that boundary.
- Simultaneous events:
  - sample_valid while hold_full=1 and not at a boundary: new value overwrites, overrun set.
  - sample_valid on the same clk as a boundary load: the boundary load takes the old hold, the new value fills hold, hold_full=1, no overrun.
  - clear_status on the same clk as a flag set: set wins.
- Reset mid-frame: outputs drop to 0 immediately; no partial word is resumed.

Optional Feature:
- Macro AUDIO_DCBLOCK_EN.
- Defined: inserts a first-order DC blocker after conversion: y = x - x_prev + y_prev - (y_prev>>>8), 18-bit signed internal, saturated to 16 bits.
  - Updated on sample_valid; state reset to 0.
  - Adds one clk of latency to hold fill.
- Undefined: the converted sample goes directly to hold.

Decomposition:
- Package audio_pkg: typedef logic signed [15:0] audio_sample_t; state enum {IDLE, RUN}; constant SILENCE_OFFSET = 16'h8000.
- One sub-module: audio_dc_block, instantiated only under AUDIO_DCBLOCK_EN.
- Divider, FIFO-less double buffer and serializer stay in the top module.

Test Plan:
- Reset, then enable=1 with no sample → stays IDLE, i2s_bclk=0, no flags.
- BCLK_HALF=8: sample_in=16'h8000 strobed → RUN. bclk period 16 clk, lrck period 512 clk, data all 0 in both slots.
- sample_in=16'hC001 → serial word 16'h4001 MSB-first in left and right slots, MSB one BCLK after each lrck edge.
- Two strobes (16'h1234 then 16'hFFFF) within one frame → overrun=1, next frame sends 16'h7FFF. clear_status → overrun=0.
- No strobe for one frame → previous word repeated, underrun=1.
- Assert rst mid-slot → all outputs 0 the same cycle. After release, IDLE until next strobe.
